core_dbg_iface: RTL and testbench
=================================

// Module: core_dbg_iface
// PURPOSE
//  Core Debug Interface register block with a parametrised ITR sequencer.
//  Decodes debugger register writes/reads and raises halt/resume pulses.
//  On trigger, injects up to NR_ITR instructions into the core fetch path,
//  one at a time, and waits for each to retire before issuing the next.
//  Sits between the debug transport (DMI/JTAG bridge) and the pipeline front end.
// PARAMETERS
//  NR_ITR     4                  number of instruction transfer slots (1..16)
//  DTR_WIDTH  64                 data transfer register width, multiple of 32
//  ADDR_WIDTH core::ADDR_WIDTH   physical address width used in InsnBundle
// PORTS
//  clk          in   1            core clock
//  rst          in   1            asynchronous reset, active-high
//  dbg_wr       in   1            debugger register write strobe
//  dbg_rd       in   1            debugger register read strobe
//  dbg_addr     in   REG_AW       register offset (REG_AW = $clog2(2+NR_ITR+DTR_WIDTH/32))
//  dbg_wdata    in   32           write data
//  dbg_rdata    out  32           read data, valid when dbg_rvalid
//  dbg_rvalid   out  1            read response, 1 cycle after dbg_rd
//  core_halted  in   1            core is in debug halt
//  halt_req     out  1            1-cycle halt request pulse
//  resume_req   out  1            1-cycle resume request pulse
//  insn_o       out  InsnBundle   injected instruction; valid bit is the handshake valid
//  insn_ready   in   1            pipeline accepts insn_o this cycle
//  insn_done    in   1            injected instruction retired
//  insn_exc     in   1            qualifies insn_done: instruction faulted
//  dtr_core_wr  in   1            core writes DTR (CSR write from injected code)
//  dtr_core_wdata in DTR_WIDTH    core DTR write data
//  dtr_q        out  DTR_WIDTH    current DTR contents (core reads)
// BEHAVIOUR
//  Map: 0 DBGSC, 1 DRUNCTRL, 2..NR_ITR+1 ITR[i], then DTR 32-bit words, MS word first.
//  DBGSC: [0] halted (RO, = core_halted); [1] itr_busy (RO); [2] itr_err (sticky, W1C);
//   [3] dtr_full (RO); [11:8] itr_cnt (RW, 0 means NR_ITR). Other bits read 0.
//  DRUNCTRL write: bit0 -> halt_req pulse next cycle; bit1 -> resume_req pulse next cycle;
//   both set -> no pulse, itr_err set. Reads of DRUNCTRL/ITR return 0.
//  Writing ITR[NR_ITR-1] is the trigger. Slots are always latched first, then FSM starts.
//  FSM states:
//   IDLE:  trigger & core_halted -> ISSUE (idx=0). Trigger & !core_halted -> set itr_err.
//   ISSUE: insn_o.valid=1, insn=ITR[idx], addr=0; insn_ready -> WAIT.
//   WAIT:  insn_done & insn_exc -> set itr_err, IDLE (remaining slots dropped).
//          insn_done & idx==cnt-1 -> IDLE; insn_done otherwise -> idx++, ISSUE.
//  First insn_o.valid is 1 cycle after trigger write; insn_o stable while valid & !ready.
//  Any ITR/DBGSC/DRUNCTRL write while itr_busy: ignored, itr_err set (W1C of err still honoured).
//  insn_done in IDLE/ISSUE: ignored.
//  DTR: debugger writes a word; dtr_full set on core write, cleared on debugger read of LS word.
//   Same-cycle core write and debugger DTR write: core wins, itr_err set.
//  Reset values: all outputs 0, dbg_rdata 0, DTR 0, itr_cnt 0, FSM IDLE.
//  Async reset mid-sequence: FSM returns to IDLE at once, no further insn_o, err cleared.
// STRUCTURE
//  Package core additions: DbgIfaceReg extended by NR_ITR;
//   DbgScReg packed struct (field layout above); DbgItrState enum {IDLE,ISSUE,WAIT}.
//  Sub-module core_dbg_itr_seq: ITR slot storage, index counter, FSM, insn_o handshake.
//  Top level holds the register decode, DBGSC/DRUNCTRL logic and DTR.
// TESTING
//  1. Halted, itr_cnt=0, write ITR0..3, ready=1, done 2 cycles after each accept ->
//     4 insns in order, busy drops the cycle after the 4th done, itr_err=0.
//  2. itr_cnt=2, trigger -> only ITR0, ITR1 issued; insn_ready held low 5 cycles ->
//     insn_o stable for all 5 cycles.
//  3. insn_exc on 2nd done -> sequence stops, ITR2/3 never issued, DBGSC reads 0x5;
//     write DBGSC=0x4 -> reads 0x1.
//  4. Not halted, trigger -> no insn_o.valid, itr_err=1; DRUNCTRL=0x3 -> no pulses.
//  5. Core writes DTR=0xDEAD_BEEF_0123_4567 -> dtr_full=1; debugger reads word 0 then
//     word 1 -> 0xDEADBEEF, 0x01234567, dtr_full=0.
//  6. Assert rst while in WAIT -> insn_o.valid=0, DBGSC reads core_halted only.

Source files
------------

// File: rtl/core_dbg_iface_pkg.sv
// Shared types and helpers for the core debug interface: register map,
// DBGSC layout, injected-instruction bundle and ITR sequencer states.
package core_dbg_iface_pkg;

   localparam int ADDR_WIDTH   = 32;
   localparam int REG_DBGSC    = 0;
   localparam int REG_DRUNCTRL = 1;
   localparam int REG_ITR0     = 2;

   typedef struct packed {
      logic                  valid;
      logic [31:0]           insn;
      logic [ADDR_WIDTH-1:0] addr;
   } insn_bundle_t;

   typedef struct packed {
      logic [19:0] rsvd_hi;
      logic [3:0]  itr_cnt;
      logic [3:0]  rsvd_lo;
      logic        dtr_full;
      logic        itr_err;
      logic        itr_busy;
      logic        halted;
   } dbg_sc_reg_t;

   typedef enum logic [1:0] {
      ITR_IDLE,
      ITR_ISSUE,
      ITR_WAIT
   } dbg_itr_state_e;

   function automatic int reg_aw(int nr_itr, int dtr_width);
      return $clog2(2 + nr_itr + dtr_width / 32);
   endfunction

   // itr_cnt of 0 (or anything beyond the slot count) runs every slot.
   function automatic int itr_last_idx(logic [3:0] cnt, int nr_itr);
      if (cnt == 4'd0 || int'(cnt) > nr_itr) return nr_itr - 1;
      return int'(cnt) - 1;
   endfunction

endpackage

// File: rtl/core_dbg_iface_if.sv
// Debugger register bus between the debug transport and the debug interface.
interface core_dbg_iface_if #(
   parameter int REG_AW = 3
) ();

   logic              wr;
   logic              rd;
   logic [REG_AW-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              rvalid;

   modport master (
      output wr, rd, addr, wdata,
      input  rdata, rvalid
   );

   modport slave (
      input  wr, rd, addr, wdata,
      output rdata, rvalid
   );

endinterface

// File: rtl/core_dbg_itr_seq.sv
// ITR sequencer: holds the instruction slots and feeds them to the core one
// at a time, waiting for each to retire before issuing the next.
module core_dbg_itr_seq
   import core_dbg_iface_pkg::*;
#(
   parameter  int NR_ITR = 4,
   localparam int IDX_W  = (NR_ITR > 1) ? $clog2(NR_ITR) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             slot_we,
   input  logic [IDX_W-1:0] slot_idx,
   input  logic [31:0]      slot_wdata,
   input  logic             trigger,
   input  logic             core_halted,
   input  logic [3:0]       itr_cnt,
   input  logic             insn_ready,
   input  logic             insn_done,
   input  logic             insn_exc,
   output insn_bundle_t     insn_o,
   output logic             busy,
   output logic             err_set
);

   dbg_itr_state_e   state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      slot_q [NR_ITR];
   logic             last_insn;

   // NOTE: the slot array is small and architecturally visible, so it is
   // reset like any other register rather than left as uninitialised RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NR_ITR; i++) slot_q[i] <= '0;
      end else if (slot_we) begin
         slot_q[slot_idx] <= slot_wdata;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ITR_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   assign last_insn = (int'(idx_q) == itr_last_idx(itr_cnt, NR_ITR));
   assign busy      = (state_q != ITR_IDLE);

   // NOTE: every output of this block gets a default first so no path
   // leaves a signal unassigned and infers a latch.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_set = 1'b0;
      insn_o  = '0;
      case (state_q)
         ITR_IDLE: begin
            if (trigger) begin
               if (core_halted) begin
                  state_d = ITR_ISSUE;
                  idx_d   = '0;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         ITR_ISSUE: begin
            insn_o.valid = 1'b1;
            insn_o.insn  = slot_q[idx_q];
            if (insn_ready) state_d = ITR_WAIT;
         end
         ITR_WAIT: begin
            if (insn_done) begin
               if (insn_exc) begin
                  err_set = 1'b1;
                  state_d = ITR_IDLE;
               end else if (last_insn) begin
                  state_d = ITR_IDLE;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ITR_ISSUE;
               end
            end
         end
         default: state_d = ITR_IDLE;
      endcase
   end

endmodule

// File: rtl/core_dbg_iface.sv
// Core debug interface: debugger register decode, DBGSC/DRUNCTRL, DTR and
// the ITR sequencer that injects instructions into the core fetch path.
module core_dbg_iface
   import core_dbg_iface_pkg::*;
#(
   parameter int NR_ITR    = 4,
   parameter int DTR_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   core_dbg_iface_if.slave      dbg,
   input  logic                 core_halted,
   output logic                 halt_req,
   output logic                 resume_req,
   output insn_bundle_t         insn_o,
   input  logic                 insn_ready,
   input  logic                 insn_done,
   input  logic                 insn_exc,
   input  logic                 dtr_core_wr,
   input  logic [DTR_WIDTH-1:0] dtr_core_wdata,
   output logic [DTR_WIDTH-1:0] dtr_q
);

   localparam int NR_DTR_W = DTR_WIDTH / 32;
   localparam int DTR_BASE = REG_ITR0 + NR_ITR;
   localparam int IDX_W    = (NR_ITR > 1) ? $clog2(NR_ITR) : 1;

   int               addr;
   int               dtr_word;
   logic             sel_sc, sel_run, sel_itr, sel_dtr;
   logic [IDX_W-1:0] itr_idx;
   logic             ctl_ok_wr, busy_err, run_err, dtr_clash, err_clr;
   logic             slot_we, trigger;
   logic             itr_busy, seq_err_set;
   logic             itr_err, dtr_full;
   logic [3:0]       itr_cnt;
   dbg_sc_reg_t      sc;
   logic [31:0]      rdata_d;

   always_comb begin
      addr     = 32'(dbg.addr);
      sel_sc   = (addr == REG_DBGSC);
      sel_run  = (addr == REG_DRUNCTRL);
      sel_itr  = (addr >= REG_ITR0) && (addr < DTR_BASE);
      sel_dtr  = (addr >= DTR_BASE) && (addr < DTR_BASE + NR_DTR_W);
      itr_idx  = IDX_W'(addr - REG_ITR0);
      dtr_word = addr - DTR_BASE;
   end

   // Control-register writes are locked out while a sequence is running;
   // clearing itr_err through DBGSC still works and does not re-raise it.
   assign ctl_ok_wr = dbg.wr && !itr_busy;
   assign busy_err  = dbg.wr && itr_busy && (sel_sc || sel_run || sel_itr)
                      && !(sel_sc && dbg.wdata[2]);
   assign run_err   = ctl_ok_wr && sel_run && dbg.wdata[0] && dbg.wdata[1];
   assign dtr_clash = dbg.wr && sel_dtr && dtr_core_wr;
   assign err_clr   = dbg.wr && sel_sc && dbg.wdata[2];
   assign slot_we   = ctl_ok_wr && sel_itr;
   assign trigger   = slot_we && (addr == DTR_BASE - 1);

   core_dbg_itr_seq #(
      .NR_ITR (NR_ITR)
   ) u_itr_seq (
      .clk         (clk),
      .rst         (rst),
      .slot_we     (slot_we),
      .slot_idx    (itr_idx),
      .slot_wdata  (dbg.wdata),
      .trigger     (trigger),
      .core_halted (core_halted),
      .itr_cnt     (itr_cnt),
      .insn_ready  (insn_ready),
      .insn_done   (insn_done),
      .insn_exc    (insn_exc),
      .insn_o      (insn_o),
      .busy        (itr_busy),
      .err_set     (seq_err_set)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         itr_cnt    <= '0;
         itr_err    <= 1'b0;
         halt_req   <= 1'b0;
         resume_req <= 1'b0;
      end else begin
         if (ctl_ok_wr && sel_sc) itr_cnt <= dbg.wdata[11:8];
         itr_err    <= seq_err_set || busy_err || run_err || dtr_clash
                       || (itr_err && !err_clr);
         halt_req   <= ctl_ok_wr && sel_run && dbg.wdata[0] && !dbg.wdata[1];
         resume_req <= ctl_ok_wr && sel_run && dbg.wdata[1] && !dbg.wdata[0];
      end
   end

   // Word 0 of the DTR window is the most significant 32 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dtr_q    <= '0;
         dtr_full <= 1'b0;
      end else if (dtr_core_wr) begin
         dtr_q    <= dtr_core_wdata;
         dtr_full <= 1'b1;
      end else begin
         for (int k = 0; k < NR_DTR_W; k++) begin
            if (dbg.wr && sel_dtr && dtr_word == k)
               dtr_q[(NR_DTR_W-1-k)*32 +: 32] <= dbg.wdata;
         end
         if (dbg.rd && sel_dtr && dtr_word == NR_DTR_W - 1) dtr_full <= 1'b0;
      end
   end

   always_comb begin
      sc          = '0;
      sc.halted   = core_halted;
      sc.itr_busy = itr_busy;
      sc.itr_err  = itr_err;
      sc.dtr_full = dtr_full;
      sc.itr_cnt  = itr_cnt;
      rdata_d     = '0;
      if (sel_sc) begin
         rdata_d = sc;
      end else if (sel_dtr) begin
         for (int k = 0; k < NR_DTR_W; k++) begin
            if (dtr_word == k) rdata_d = dtr_q[(NR_DTR_W-1-k)*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg.rvalid <= 1'b0;
         dbg.rdata  <= '0;
      end else begin
         dbg.rvalid <= dbg.rd;
         if (dbg.rd) dbg.rdata <= rdata_d;
      end
   end

endmodule

// File: tb/tb_core_dbg_iface.sv
// Bench for core_dbg_iface: directed scenarios against a transaction-level
// model of the register block and the injected instruction stream.
module tb_core_dbg_iface;
   import core_dbg_iface_pkg::*;

   localparam int NR_ITR    = 4;
   localparam int DTR_WIDTH = 64;
   localparam int REG_AW    = reg_aw(NR_ITR, DTR_WIDTH);

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 core_halted;
   logic                 halt_req, resume_req;
   insn_bundle_t         insn_o;
   logic                 insn_ready, insn_done, insn_exc;
   logic                 dtr_core_wr;
   logic [DTR_WIDTH-1:0] dtr_core_wdata;
   logic [DTR_WIDTH-1:0] dtr_q;

   core_dbg_iface_if #(.REG_AW(REG_AW)) dbg ();

   core_dbg_iface #(
      .NR_ITR    (NR_ITR),
      .DTR_WIDTH (DTR_WIDTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .dbg            (dbg),
      .core_halted    (core_halted),
      .halt_req       (halt_req),
      .resume_req     (resume_req),
      .insn_o         (insn_o),
      .insn_ready     (insn_ready),
      .insn_done      (insn_done),
      .insn_exc       (insn_exc),
      .dtr_core_wr    (dtr_core_wr),
      .dtr_core_wdata (dtr_core_wdata),
      .dtr_q          (dtr_q)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: expected pending instruction stream and register contents.
   logic [31:0] m_q[$];
   logic        m_wait;
   logic [31:0] m_slot [NR_ITR];
   logic [3:0]  m_cnt;
   logic        m_err, m_full, m_halt, m_resume, m_rvalid;
   logic [31:0] m_rdata;
   logic [63:0] m_dtr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_wait = 0; m_cnt = 0; m_err = 0; m_full = 0; m_dtr = 0;
         m_halt = 0; m_resume = 0; m_rvalid = 0; m_rdata = 0;
         foreach (m_slot[i]) m_slot[i] = 0;
      end else begin : step
         bit busy0, set_err, clr_err, ctl_wr;
         int a, n;
         busy0   = m_q.size() > 0;
         a       = int'(dbg.addr);
         set_err = 0;
         clr_err = dbg.wr && a == 0 && dbg.wdata[2];
         m_rvalid = dbg.rd;
         if (dbg.rd)
            m_rdata = (a == 0) ? {20'd0, m_cnt, 4'd0, m_full, m_err, busy0, core_halted} :
                      (a == 6) ? m_dtr[63:32] : (a == 7) ? m_dtr[31:0] : 32'd0;
         if (busy0 && !m_wait && insn_ready) begin
            m_wait = 1;
         end else if (busy0 && m_wait && insn_done) begin
            if (insn_exc) begin set_err = 1; m_q.delete(); end
            else void'(m_q.pop_front());
            m_wait = 0;
         end
         m_halt = 0; m_resume = 0;
         ctl_wr = dbg.wr && a < 6;
         if (ctl_wr && busy0) begin
            if (!(a == 0 && dbg.wdata[2])) set_err = 1;
         end else if (ctl_wr) begin
            if (a == 0) m_cnt = dbg.wdata[11:8];
            else if (a == 1) begin
               if (dbg.wdata[1:0] == 2'b11) set_err = 1;
               else begin m_halt = dbg.wdata[0]; m_resume = dbg.wdata[1]; end
            end else begin
               m_slot[a-2] = dbg.wdata;
               if (a == 5) begin
                  if (core_halted) begin
                     n = (m_cnt == 0 || m_cnt > 4) ? 4 : int'(m_cnt);
                     for (int i = 0; i < n; i++) m_q.push_back(m_slot[i]);
                     m_wait = 0;
                  end else set_err = 1;
               end
            end
         end
         if (dtr_core_wr) begin
            m_dtr = dtr_core_wdata; m_full = 1;
            if (dbg.wr && (a == 6 || a == 7)) set_err = 1;
         end else begin
            if (dbg.wr && a == 6) m_dtr[63:32] = dbg.wdata;
            if (dbg.wr && a == 7) m_dtr[31:0]  = dbg.wdata;
            if (dbg.rd && a == 7) m_full = 0;
         end
         m_err = set_err || (m_err && !clr_err);
      end
   end

   always @(negedge clk) begin
      check("insn_valid", insn_o.valid, (m_q.size() > 0 && !m_wait));
      if (m_q.size() > 0 && !m_wait) check("insn_data", insn_o.insn, m_q[0]);
      check("insn_addr", insn_o.addr, 0);
      check("halt_req", halt_req, m_halt);
      check("resume_req", resume_req, m_resume);
      check("rvalid", dbg.rvalid, m_rvalid);
      if (m_rvalid) check("rdata", dbg.rdata, m_rdata);
      check("dtr_q", dtr_q, m_dtr);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(int a, logic [31:0] d);
      dbg.wr = 1'b1; dbg.addr = REG_AW'(a); dbg.wdata = d;
      tick();
      dbg.wr = 1'b0;
   endtask

   task automatic reg_rd(int a, output logic [31:0] d);
      dbg.rd = 1'b1; dbg.addr = REG_AW'(a);
      tick();
      dbg.rd = 1'b0;
      d = dbg.rdata;
   endtask

   // Pipeline stand-in: accept after ready_lat stalled cycles, retire 2 cycles later.
   task automatic serve_one(int ready_lat, bit exc, output logic [31:0] got);
      int guard = 0;
      got = '0;
      while (!insn_o.valid && guard < 20) begin tick(); guard++; end
      if (!insn_o.valid) begin
         check("insn_valid_timeout", insn_o.valid, 1);
         return;
      end
      got = insn_o.insn;
      for (int i = 0; i < ready_lat; i++) begin
         tick();
         check("insn_hold_valid", insn_o.valid, 1);
         check("insn_hold_data", insn_o.insn, got);
      end
      insn_ready = 1'b1; tick(); insn_ready = 1'b0;
      tick();
      insn_done = 1'b1; insn_exc = exc;
      tick();
      insn_done = 1'b0; insn_exc = 1'b0;
   endtask

   task automatic idle_no_issue(string name, int cycles);
      for (int i = 0; i < cycles; i++) begin
         tick();
         check(name, insn_o.valid, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r, got;
      rst = 1'b1; core_halted = 1'b0;
      dbg.wr = 1'b0; dbg.rd = 1'b0; dbg.addr = '0; dbg.wdata = '0;
      insn_ready = 1'b0; insn_done = 1'b0; insn_exc = 1'b0;
      dtr_core_wr = 1'b0; dtr_core_wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_halt_req", halt_req, 0);
      check("rst_dtr", dtr_q, 0);
      reg_rd(0, r); check("rst_dbgsc", r, 32'h0);

      // 1: full four-slot sequence
      core_halted = 1'b1;
      reg_wr(2, 32'h0000_0013);
      reg_wr(3, 32'h0010_0093);
      reg_wr(4, 32'h0020_0113);
      reg_wr(5, 32'h0030_0193);
      check("t1_first_valid", insn_o.valid, 1);
      reg_rd(0, r); check("t1_dbgsc_busy", r, 32'h3);
      serve_one(0, 0, got); check("t1_insn0", got, 32'h0000_0013);
      serve_one(0, 0, got); check("t1_insn1", got, 32'h0010_0093);
      serve_one(0, 0, got); check("t1_insn2", got, 32'h0020_0113);
      serve_one(0, 0, got); check("t1_insn3", got, 32'h0030_0193);
      reg_rd(0, r); check("t1_dbgsc_done", r, 32'h1);

      // 2: itr_cnt=2 with a stalled accept
      reg_wr(0, 32'h200);
      reg_wr(5, 32'h0030_0193);
      serve_one(5, 0, got); check("t2_insn0", got, 32'h0000_0013);
      serve_one(0, 0, got); check("t2_insn1", got, 32'h0010_0093);
      idle_no_issue("t2_no_more", 3);
      reg_rd(0, r); check("t2_dbgsc", r, 32'h201);

      // Write while busy is ignored and flags an error
      reg_wr(0, 32'h100);
      reg_wr(5, 32'h0030_0193);
      reg_wr(2, 32'h0000_0BAD);
      reg_rd(0, r); check("busy_wr_dbgsc", r, 32'h107);
      serve_one(0, 0, got); check("busy_wr_insn", got, 32'h0000_0013);
      reg_rd(0, r); check("busy_wr_after", r, 32'h105);
      reg_wr(0, 32'h4);
      reg_rd(0, r); check("busy_wr_clr", r, 32'h1);

      // 3: fault on the second instruction aborts the sequence
      reg_wr(5, 32'h0030_0193);
      serve_one(0, 0, got); check("t3_insn0", got, 32'h0000_0013);
      serve_one(0, 1, got); check("t3_insn1", got, 32'h0010_0093);
      idle_no_issue("t3_dropped", 4);
      reg_rd(0, r); check("t3_dbgsc_err", r, 32'h5);
      reg_wr(0, 32'h4);
      reg_rd(0, r); check("t3_dbgsc_clr", r, 32'h1);

      // 4: trigger while running, and run-control pulses
      core_halted = 1'b0;
      reg_wr(5, 32'h0030_0193);
      check("t4_no_valid", insn_o.valid, 0);
      idle_no_issue("t4_no_issue", 3);
      reg_rd(0, r); check("t4_dbgsc_err", r, 32'h4);
      reg_wr(1, 32'h3);
      check("t4_both_halt", halt_req, 0);
      check("t4_both_resume", resume_req, 0);
      reg_wr(1, 32'h1);
      check("t4_halt_pulse", halt_req, 1);
      tick();
      check("t4_halt_end", halt_req, 0);
      reg_wr(1, 32'h2);
      check("t4_resume_pulse", resume_req, 1);
      reg_wr(0, 32'h4);
      reg_rd(0, r); check("t4_dbgsc_clr", r, 32'h0);

      // 5: DTR exchange
      dtr_core_wdata = 64'hDEAD_BEEF_0123_4567; dtr_core_wr = 1'b1;
      tick();
      dtr_core_wr = 1'b0;
      check("t5_dtr_q", dtr_q, 64'hDEAD_BEEF_0123_4567);
      reg_rd(0, r); check("t5_full", r, 32'h8);
      reg_rd(6, r); check("t5_word0", r, 32'hDEAD_BEEF);
      reg_rd(7, r); check("t5_word1", r, 32'h0123_4567);
      reg_rd(0, r); check("t5_empty", r, 32'h0);
      reg_wr(7, 32'hCAFE_F00D);
      check("t5_dbg_wr", dtr_q, 64'hDEAD_BEEF_CAFE_F00D);
      dtr_core_wdata = 64'h1111_1111_1111_1111; dtr_core_wr = 1'b1;
      reg_wr(6, 32'h2222_2222);
      dtr_core_wr = 1'b0;
      check("t5_clash_dtr", dtr_q, 64'h1111_1111_1111_1111);
      reg_rd(0, r); check("t5_clash_dbgsc", r, 32'hC);

      // 6: reset while waiting for retirement
      core_halted = 1'b1;
      reg_wr(5, 32'h0030_0193);
      check("t6_issue", insn_o.valid, 1);
      insn_ready = 1'b1; tick(); insn_ready = 1'b0;
      check("t6_wait", insn_o.valid, 0);
      #2 rst = 1'b1;
      #1 check("t6_rst_valid", insn_o.valid, 0);
      tick();
      rst = 1'b0;
      insn_done = 1'b1; tick(); insn_done = 1'b0;
      idle_no_issue("t6_no_issue", 3);
      reg_rd(0, r); check("t6_dbgsc", r, 32'h1);

      tick();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
